// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, single-entry instruction buffer to decode.
// Optional macro FETCH_PERF_EN adds a saturating count of instructions accepted by decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] flush_addr_q, flush_addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_addr_d = flush_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = redirect_pc;
      end
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // Without an ack the old read is still in flight and must be drained.
          if (!mem_ack) begin
            flush_addr_d = pc_q;
            state_d      = FLUSH;
          end
        end else if (mem_ack) begin
          instr_d  = mem_rdata;
          pc_out_d = pc_q + 16'd1;
          pc_d     = pc_q + 16'd1;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (redirect) pc_d = redirect_pc;
        if (mem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      flush_addr_q <= RESET_PC;
      instr_q      <= 16'h0000;
      pc_out_q     <= 16'h0000;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

  assign mem_req     = (state_q == FETCH) || (state_q == FLUSH);
  assign mem_addr    = (state_q == FLUSH) ? flush_addr_q : pc_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign inst_valid  = valid_q;

`ifdef FETCH_PERF_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (valid_q && inst_ready && !redirect && (count_q != 16'hFFFF))
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 16'h0000;
    else        count_q <= count_d;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(16'h3000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction(instruction), .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: "starting" = first cycle after reset, "busy" = a read is outstanding,
  // "stale" = the outstanding read belongs to a superseded PC and its data will be dropped.
  bit          m_starting, m_busy, m_stale, m_valid;
  logic [15:0] m_pc, m_stale_addr, m_inst, m_pcout;
  int          m_count;

  task automatic model_reset();
    m_starting = 1; m_busy = 0; m_stale = 0; m_valid = 0;
    m_pc = 16'h3000; m_stale_addr = 16'h3000; m_inst = 16'h0000; m_pcout = 16'h0000;
    m_count = 0;
  endtask

  task automatic model_edge(input bit rd, input logic [15:0] rpc, input bit ack,
                            input logic [15:0] rdata, input bit rdy);
    if (m_starting) begin
      m_starting = 0; m_busy = 1;
      if (rd) m_pc = rpc;
    end else if (m_valid) begin
      if (rdy && !rd && m_count < 65535) m_count++;
      if (rd || rdy) begin
        if (rd) m_pc = rpc;
        m_valid = 0; m_busy = 1;
      end
    end else if (m_stale) begin
      if (rd) m_pc = rpc;
      if (ack) m_stale = 0;
    end else if (m_busy) begin
      if (rd) begin
        if (!ack) begin m_stale = 1; m_stale_addr = m_pc; end
        m_pc = rpc;
      end else if (ack) begin
        m_inst = rdata; m_pcout = m_pc + 16'd1; m_pc = m_pc + 16'd1;
        m_valid = 1; m_busy = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the rising edge, return at the falling edge.
  task automatic cyc(input bit rd, input logic [15:0] rpc, input bit ack,
                     input logic [15:0] rdata, input bit rdy);
    redirect = rd; redirect_pc = rpc; mem_ack = ack; mem_rdata = rdata; inst_ready = rdy;
    @(posedge clk);
    if (rst_n) model_edge(rd, rpc, ack, rdata, rdy);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; redirect = 0; redirect_pc = 0; mem_ack = 1; mem_rdata = 16'hFFFF; inst_ready = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 16'h3000) begin n_err++; $display("FAIL reset_addr: got %h want 3000", mem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_cmp++; if (instruction !== 16'h0000) begin n_err++; $display("FAIL reset_inst: got %h want 0000", instruction); end
    n_cmp++; if (pc_out !== 16'h0000) begin n_err++; $display("FAIL reset_pcout: got %h want 0000", pc_out); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (fetch_count !== 16'h0000) begin n_err++; $display("FAIL reset_count: got %h want 0000", fetch_count); end
`endif
  endtask

  task automatic test_basic();
    rst_n = 1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", mem_req); end
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 16'h3000}) begin n_err++; $display("FAIL first_addr: got %b/%h want 1/3000", mem_req, mem_addr); end
    cyc(0, 0, 1, 16'h1234, 1);
    n_cmp++; if ({inst_valid, instruction, pc_out} !== {1'b1, 16'h1234, 16'h3001}) begin
      n_err++; $display("FAIL first_inst: got %b/%h/%h want 1/1234/3001", inst_valid, instruction, pc_out); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", mem_req); end
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 16'h3001, 1'b0}) begin
      n_err++; $display("FAIL second_addr: got %b/%h/%b want 1/3001/0", mem_req, mem_addr, inst_valid); end
  endtask

  task automatic test_hold();
    cyc(0, 0, 1, 16'hBEEF, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1'($urandom_range(0, 1)), 16'($urandom), 0);
      n_cmp++; if ({inst_valid, instruction, pc_out, mem_req} !== {1'b1, 16'hBEEF, 16'h3002, 1'b0}) begin
        n_err++; $display("FAIL hold_stable[%0d]: got %b/%h/%h/%b want 1/beef/3002/0", i, inst_valid, instruction, pc_out, mem_req); end
    end
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 16'h3002}) begin n_err++; $display("FAIL after_hold_addr: got %b/%h want 1/3002", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_flush();
    cyc(1, 16'h4000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 16'h3002, 1'b0}) begin
        n_err++; $display("FAIL flush_hold[%0d]: got %b/%h/%b want 1/3002/0", i, mem_req, mem_addr, inst_valid); end
      if (i < 2) cyc(0, 0, 0, 0, 0);
      else       cyc(0, 0, 1, 16'hDEAD, 1);
    end
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 16'h4000, 1'b0}) begin
      n_err++; $display("FAIL flush_target: got %b/%h/%b want 1/4000/0", mem_req, mem_addr, inst_valid); end
    cyc(0, 0, 1, 16'h5555, 0);
    n_cmp++; if ({inst_valid, instruction, pc_out} !== {1'b1, 16'h5555, 16'h4001}) begin
      n_err++; $display("FAIL flush_next_inst: got %b/%h/%h want 1/5555/4001", inst_valid, instruction, pc_out); end
  endtask

  task automatic test_wrap();
    cyc(1, 16'hFFFF, 0, 0, 1);
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 16'hFFFF, 1'b0}) begin
      n_err++; $display("FAIL wrap_addr: got %b/%h/%b want 1/ffff/0", mem_req, mem_addr, inst_valid); end
    cyc(0, 0, 1, 16'h0A0A, 0);
    n_cmp++; if ({inst_valid, pc_out} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL wrap_pcout: got %b/%h want 1/0000", inst_valid, pc_out); end
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL wrap_next: got %b/%h want 1/0000", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid();
    mem_ack = 1; mem_rdata = 16'h7777;
    #3 rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if ({mem_req, mem_addr, inst_valid, instruction, pc_out} !== {1'b0, 16'h3000, 1'b0, 16'h0000, 16'h0000}) begin
      n_err++; $display("FAIL async_reset: got %b/%h/%b/%h/%h want 0/3000/0/0000/0000", mem_req, mem_addr, inst_valid, instruction, pc_out); end
    @(negedge clk);
    rst_n = 1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %b want 0", mem_req); end
    cyc(0, 0, 1, 16'h7777, 0);
    n_cmp++; if ({mem_req, mem_addr, inst_valid} !== {1'b1, 16'h3000, 1'b0}) begin
      n_err++; $display("FAIL reset_refetch: got %b/%h/%b want 1/3000/0", mem_req, mem_addr, inst_valid); end
    cyc(0, 0, 1, 16'h8888, 0);
    n_cmp++; if ({inst_valid, instruction, pc_out} !== {1'b1, 16'h8888, 16'h3001}) begin
      n_err++; $display("FAIL reset_first_inst: got %b/%h/%h want 1/8888/3001", inst_valid, instruction, pc_out); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_perf();
`ifdef FETCH_PERF_EN
    rst_n = 0; model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 16'(i), 0);
      cyc(0, 0, 0, 0, 1);
    end
    cyc(0, 0, 1, 16'h0099, 0);
    cyc(1, 16'h5000, 0, 0, 1);
    n_cmp++; if (fetch_count !== 16'd3) begin n_err++; $display("FAIL perf_count: got %0d want 3", fetch_count); end
`endif
  endtask

  task automatic test_random();
    bit          rd, ack, rdy;
    logic [15:0] rpc;
    logic [49:0] act, exp;
    for (int i = 0; i < 3000; i++) begin
      rd  = ($urandom_range(0, 5) == 0);
      ack = $urandom_range(0, 1) == 1;
      rdy = $urandom_range(0, 2) != 0;
      rpc = 16'($urandom);
      if (m_stale && rd) ack = 0;
      cyc(rd, rpc, ack, 16'($urandom), rdy);
      exp = {m_busy, m_busy ? (m_stale ? m_stale_addr : m_pc) : 16'h0000, m_valid, m_inst, m_pcout};
      act = {mem_req, mem_req ? mem_addr : 16'h0000, inst_valid, instruction, pc_out};
      n_cmp++; if (act !== exp) begin n_err++; $display("FAIL random[%0d]: got %h want %h", i, act, exp); end
`ifdef FETCH_PERF_EN
      n_cmp++; if (fetch_count !== 16'(m_count)) begin n_err++; $display("FAIL random_count[%0d]: got %0d want %0d", i, fetch_count, m_count); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_redirect_flush();
    test_wrap();
    test_reset_mid();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
